// File: rtl/irq_encoder.sv
// +--------------------------------------------------------------------------+
// | irq_encoder: sticky pending register + priority encoder, valid/ack hand-   |
// | off of the lowest-index pending line (line 0 reserved). Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_encoder #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BUS_WIDTH-1:0]     req_in,
  input  logic [BUS_WIDTH-1:0]     mask,
  input  logic                     irq_ack,
  output logic                     irq_valid,
  output logic [ADDRESS_WIDTH-1:0] irq_id,
  output logic [BUS_WIDTH-1:0]     pending
);

  localparam logic [BUS_WIDTH-1:0] C_LINE_EN = ~BUS_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [BUS_WIDTH-1:0]       r_pending;
  logic [ADDRESS_WIDTH-1:0]   r_id;
  logic [ADDRESS_WIDTH-1:0]   w_winner;
  logic                       w_load;
  logic                       w_accept;
  logic [BUS_WIDTH-1:0]       w_clr;

  // Scan from the top down so the lowest nonzero index is the last to write.
  always_comb begin
    w_winner = '0;
    for (int i = BUS_WIDTH - 1; i >= 1; i--) begin
      if (r_pending[i]) w_winner = ADDRESS_WIDTH'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending != '0) begin
          w_load       = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          w_accept     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A new set on the same edge as the clear keeps the line pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_id      <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | (req_in & mask & C_LINE_EN);
      if (w_load) r_id <= w_winner;
    end
  end

  assign irq_valid = (r_state == PRESENT);
  assign irq_id    = r_id;
  assign pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_irq_encoder.sv
// Directed testbench for irq_encoder: each scenario task drives vectors and
// compares outputs against hand-computed values one step after each rising edge.
`default_nettype none

module tb_irq_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_encoder #(.BUS_WIDTH(8), .ADDRESS_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0; mask = 8'hFF; irq_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 8'hFF; mask = 8'hFF; irq_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({pending, irq_valid, irq_id} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: pending=%h valid=%b id=%0d, want 00/0/0", c, pending, irq_valid, irq_id);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (pending !== 8'hFE || irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_e0: pending=%h valid=%b, want fe/0", pending, irq_valid);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_release_e1: valid=%b id=%0d, want 1/1", irq_valid, irq_id);
    end
  endtask

  task automatic test_single_pulse();
    do_reset();
    req_in = 8'h20;
    tick();
    req_in = '0;
    n_checks++;
    if (pending !== 8'h20 || irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_latch: pending=%h valid=%b, want 20/0", pending, irq_valid);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin
      n_fail++;
      $display("FAIL pulse_present: valid=%b id=%0d, want 1/5", irq_valid, irq_id);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin
        n_fail++;
        $display("FAIL pulse_hold[%0d]: valid=%b id=%0d, want 1/5", c, irq_valid, irq_id);
      end
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if (irq_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL pulse_ack: valid=%b pending=%h, want 0/00", irq_valid, pending);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_after_ack: valid=%b, want 0", irq_valid);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_ids [3];
    logic [7:0] exp_pend [3];
    exp_ids  = '{3'd3, 3'd1, 3'd6};
    exp_pend = '{8'h42, 8'h40, 8'h00};
    do_reset();
    req_in = 8'h48;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h02;
    tick();
    req_in = '0;
    n_checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd3 || pending !== 8'h4A) begin
      n_fail++;
      $display("FAIL prio_no_preempt: valid=%b id=%0d pending=%h, want 1/3/4a", irq_valid, irq_id, pending);
    end
    for (int g = 0; g < 3; g++) begin
      if (g > 0) begin
        tick();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== exp_ids[g]) begin
          n_fail++;
          $display("FAIL prio_grant[%0d]: valid=%b id=%0d, want 1/%0d", g, irq_valid, irq_id, exp_ids[g]);
        end
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      n_checks++;
      if (irq_valid !== 1'b0 || pending !== exp_pend[g]) begin
        n_fail++;
        $display("FAIL prio_ack[%0d]: valid=%b pending=%h, want 0/%h", g, irq_valid, pending, exp_pend[g]);
      end
    end
  endtask

  task automatic test_line0_mask();
    do_reset();
    req_in = 8'h01;
    tick();
    req_in = '0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (pending !== 8'h00 || irq_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL line0[%0d]: pending=%h valid=%b, want 00/0", c, pending, irq_valid);
      end
      tick();
    end
    mask = 8'hFB; req_in = 8'h04;
    tick();
    req_in = '0;
    tick();
    n_checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_block: pending=%h valid=%b, want 00/0", pending, irq_valid);
    end
    mask = 8'hFF; req_in = 8'h10;
    tick();
    req_in = '0; mask = 8'hEF;
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd4 || pending !== 8'h10) begin
      n_fail++;
      $display("FAIL mask_pending_eligible: valid=%b id=%0d pending=%h, want 1/4/10", irq_valid, irq_id, pending);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0; mask = 8'hFF;
  endtask

  task automatic test_set_wins();
    do_reset();
    req_in = 8'h04;
    tick();
    req_in = '0;
    tick();
    irq_ack = 1'b1; req_in = 8'h04;
    tick();
    irq_ack = 1'b0; req_in = '0;
    n_checks++;
    if (pending !== 8'h04 || irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL set_wins_collide: pending=%h valid=%b, want 04/0", pending, irq_valid);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin
      n_fail++;
      $display("FAIL set_wins_represent: valid=%b id=%0d, want 1/2", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_stray_ack_reset();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if (irq_valid !== 1'b0 || pending !== 8'h00 || irq_id !== 3'd2) begin
      n_fail++;
      $display("FAIL stray_ack: valid=%b pending=%h id=%0d, want 0/00/2", irq_valid, pending, irq_id);
    end
    req_in = 8'h80;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h08;
    tick();
    req_in = '0;
    n_checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd7 || pending !== 8'h88) begin
      n_fail++;
      $display("FAIL midop_setup: valid=%b id=%0d pending=%h, want 1/7/88", irq_valid, irq_id, pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin
      n_fail++;
      $display("FAIL midop_reset: pending=%h valid=%b id=%0d, want 00/0/0", pending, irq_valid, irq_id);
    end
    tick();
    n_checks++;
    if (irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_after_reset: valid=%b, want 0", irq_valid);
    end
  endtask

  initial begin
    rst = 1'b1; req_in = '0; mask = 8'hFF; irq_ack = 1'b0;
    test_reset();
    test_single_pulse();
    test_priority();
    test_line0_mask();
    test_set_wins();
    test_stray_ack_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
